// File: rtl/dma_request_arbiter_if.sv
// Request/grant bundle between two DMA requesters, the arbiter and the DMA word controller.
// The arbiter connects through the master modport; the requester/controller side through slave.
interface dma_request_arbiter_if #(
    parameter int SIZE_BIT = 5
);
    logic [1:0]        i_Req;
    logic [1:0]        i_Control0;
    logic [1:0]        i_Control1;
    logic [31:0]       i_Pointer0;
    logic [31:0]       i_Pointer1;
    logic [SIZE_BIT:0] i_Count0;
    logic [SIZE_BIT:0] i_Count1;
    logic              i_Acknowlege;
    logic [2:0]        i_SM_Main;

    logic              o_Bus_Grant;
    logic [1:0]        o_Control;
    logic [31:0]       o_bram_pointer;
    logic [SIZE_BIT:0] o_Data_Counter;
    logic [1:0]        o_Owner;
    logic [1:0]        o_Done;
    logic [1:0]        o_Error;
    logic              o_Busy;

    // Handshake: a requester holds i_Req high until it sees its o_Done or o_Error bit;
    // o_Bus_Grant is a one-cycle pulse and i_Acknowlege is only honoured while waiting.
    modport master (
        input  i_Req, i_Control0, i_Control1, i_Pointer0, i_Pointer1,
               i_Count0, i_Count1, i_Acknowlege, i_SM_Main,
        output o_Bus_Grant, o_Control, o_bram_pointer, o_Data_Counter,
               o_Owner, o_Done, o_Error, o_Busy
    );

    modport slave (
        output i_Req, i_Control0, i_Control1, i_Pointer0, i_Pointer1,
               i_Count0, i_Count1, i_Acknowlege, i_SM_Main,
        input  o_Bus_Grant, o_Control, o_bram_pointer, o_Data_Counter,
               o_Owner, o_Done, o_Error, o_Busy
    );
endinterface

// File: rtl/dma_request_arbiter.sv
// Two-requester round-robin arbiter in front of a DMA word controller.
// Optional acknowledge watchdog is compiled in with `define DMA_ARB_TIMEOUT_EN.
module dma_request_arbiter #(
    parameter int SIZE_BIT       = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_n,
    dma_request_arbiter_if.master arb,
    output logic [1:0]            o_Dbg_State
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        WAIT_ACK = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [1:0]        owner_q, owner_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        error_q, error_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [31:0]       ptr_q, ptr_d;
    logic [SIZE_BIT:0] cnt_q, cnt_d;

    logic [1:0]        eligible;
    logic              winner;
    logic [1:0]        win_ctrl;
    logic [31:0]       win_ptr;
    logic [SIZE_BIT:0] win_cnt;
    logic              win_zero_burst;
    logic              owner_idx;
    logic              tmo_hit;

    // A requester whose completion is still being pulsed has not yet had a chance to drop
    // i_Req, so it is kept out of arbitration for that cycle.
    assign eligible  = arb.i_Req & ~(done_q | error_q);
    assign winner    = (eligible == 2'b11) ? ~last_q : eligible[1];
    assign win_ctrl  = winner ? arb.i_Control1 : arb.i_Control0;
    assign win_ptr   = winner ? arb.i_Pointer1 : arb.i_Pointer0;
    assign win_cnt   = winner ? arb.i_Count1   : arb.i_Count0;
    assign win_zero_burst = ~win_ctrl[1] && (win_cnt == '0);
    assign owner_idx = owner_q[1];

`ifdef DMA_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = '0;
        if (state_q == WAIT_ACK) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        done_d  = 2'b00;
        error_d = 2'b00;
        ctrl_d  = ctrl_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if ((eligible != 2'b00) && (arb.i_SM_Main == 3'd0)) begin
                    if (win_zero_burst) begin
                        // Empty burst: completed with an error, never handed to the controller.
                        done_d[winner]  = 1'b1;
                        error_d[winner] = 1'b1;
                        last_d          = winner;
                    end else begin
                        state_d = GRANT;
                        owner_d = winner ? 2'b10 : 2'b01;
                        ctrl_d  = win_ctrl;
                        ptr_d   = win_ptr;
                        cnt_d   = win_cnt;
                    end
                end
            end
            GRANT: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (arb.i_Acknowlege) begin
                    done_d  = owner_q;
                    last_d  = owner_idx;
                    state_d = RELEASE;
                end else if (tmo_hit) begin
                    error_d = owner_q;
                    last_d  = owner_idx;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                owner_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 2'b00;
            done_q  <= 2'b00;
            error_q <= 2'b00;
            ctrl_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            done_q  <= done_d;
            error_q <= error_d;
            ctrl_q  <= ctrl_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign arb.o_Bus_Grant    = (state_q == GRANT);
    assign arb.o_Busy         = (state_q != IDLE);
    assign arb.o_Owner        = owner_q;
    assign arb.o_Done         = done_q;
    assign arb.o_Error        = error_q;
    assign arb.o_Control      = ctrl_q;
    assign arb.o_bram_pointer = ptr_q;
    assign arb.o_Data_Counter = cnt_q;
    assign o_Dbg_State        = state_q;

    a_tmo_param: assert property (@(posedge i_Clock) TIMEOUT_CYCLES > 0);

    a_grant_pulse: assert property (@(posedge i_Clock) disable iff (!i_Reset_n)
        arb.o_Bus_Grant |=> !arb.o_Bus_Grant);

    a_owner_onehot0: assert property (@(posedge i_Clock) disable iff (!i_Reset_n)
        $onehot0(owner_q));

    a_busy_has_owner: assert property (@(posedge i_Clock) disable iff (!i_Reset_n)
        (state_q != IDLE) |-> $onehot(owner_q));

endmodule

// File: tb/tb_dma_request_arbiter.sv
// Randomized bench for dma_request_arbiter against a transaction-level model of the
// round-robin rules; also covers reset, i_SM_Main gating, empty bursts and the watchdog.
module tb_dma_request_arbiter;

    localparam int SIZE_BIT = 5;
    localparam int TMO      = 16;

    logic       i_Clock   = 1'b0;
    logic       i_Reset_n = 1'b0;
    logic [1:0] dbg_state;

    dma_request_arbiter_if #(.SIZE_BIT(SIZE_BIT)) arb_if ();

    dma_request_arbiter #(
        .SIZE_BIT       (SIZE_BIT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_Clock     (i_Clock),
        .i_Reset_n   (i_Reset_n),
        .arb         (arb_if),
        .o_Dbg_State (dbg_state)
    );

    // clock / reset
    always #5 i_Clock = ~i_Clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // scoreboard state
    int         total = 0;
    int         bad   = 0;
    int         first_lat;
    logic [1:0] exp_q[$];

    // requester model: pending set, their fields, and who was served last
    logic [1:0]        pend;
    logic              last_served;
    logic [1:0]        ctl [2];
    logic [31:0]       ptr [2];
    logic [SIZE_BIT:0] cnt [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Round-robin rule: with both pending the one not served last wins.
    function automatic logic pick(input logic [1:0] p, input logic last);
        if (p == 2'b11) return ~last;
        return p[1];
    endfunction

    // driver tasks
    task automatic drive_req();
        arb_if.i_Req      = pend;
        arb_if.i_Control0 = ctl[0];
        arb_if.i_Control1 = ctl[1];
        arb_if.i_Pointer0 = ptr[0];
        arb_if.i_Pointer1 = ptr[1];
        arb_if.i_Count0   = cnt[0];
        arb_if.i_Count1   = cnt[1];
    endtask

    task automatic set_req(input int r, input logic [1:0] c, input logic [31:0] p,
                           input logic [SIZE_BIT:0] n);
        ctl[r]  = c;
        ptr[r]  = p;
        cnt[r]  = n;
        pend[r] = 1'b1;
    endtask

    task automatic rand_req(input int r);
        logic [SIZE_BIT:0] n;
        n = ($urandom_range(0, 3) == 0) ? '0 : (SIZE_BIT+1)'($urandom_range(0, (1 << (SIZE_BIT+1)) - 1));
        set_req(r, 2'($urandom_range(0, 3)), $urandom, n);
    endtask

    task automatic scramble(input logic w);
        if (w) begin
            arb_if.i_Control1 = 2'($urandom_range(0, 3));
            arb_if.i_Pointer1 = $urandom;
            arb_if.i_Count1   = (SIZE_BIT+1)'($urandom);
        end else begin
            arb_if.i_Control0 = 2'($urandom_range(0, 3));
            arb_if.i_Pointer0 = $urandom;
            arb_if.i_Count0   = (SIZE_BIT+1)'($urandom);
        end
    endtask

    task automatic wait_event(output bit ok, output int lat);
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (arb_if.o_Bus_Grant || (arb_if.o_Done != 2'b00) || (arb_if.o_Error != 2'b00)) begin
                ok  = 1'b1;
                lat = i;
                break;
            end
            @(negedge i_Clock);
        end
    endtask

    // Serve every pending requester to completion, acking after dmin..dmax idle cycles.
    task automatic serve_all(input int dmin, input int dmax);
        logic              w;
        logic [1:0]        oh;
        bit                ok;
        bit                first;
        int                lat;
        int                d;
        logic [1:0]        e_ctl;
        logic [31:0]       e_ptr;
        logic [SIZE_BIT:0] e_cnt;
        first = 1'b1;
        while (pend != 2'b00) begin
            w = pick(pend, last_served);
            exp_q.push_back(w ? 2'b10 : 2'b01);
            wait_event(ok, lat);
            check("event_seen", 64'(ok), 1);
            if (first) first_lat = lat;
            first = 1'b0;
            oh = exp_q.pop_front();
            if (!ok) begin
                pend = 2'b00;
                drive_req();
                return;
            end
            e_ctl = ctl[w];
            e_ptr = ptr[w];
            e_cnt = cnt[w];
            if (!e_ctl[1] && (e_cnt == '0)) begin
                check("zb_done", arb_if.o_Done, oh);
                check("zb_error", arb_if.o_Error, oh);
                check("zb_nogrant", arb_if.o_Bus_Grant, 0);
                check("zb_busy", arb_if.o_Busy, 0);
                pend[w]     = 1'b0;
                last_served = w;
                drive_req();
                @(negedge i_Clock);
                check("zb_pulse", (arb_if.o_Done | arb_if.o_Error) & oh, 0);
            end else begin
                check("grant", arb_if.o_Bus_Grant, 1);
                check("owner", arb_if.o_Owner, oh);
                check("ctl", arb_if.o_Control, e_ctl);
                check("ptr", arb_if.o_bram_pointer, e_ptr);
                check("cnt", arb_if.o_Data_Counter, e_cnt);
                check("busy_grant", arb_if.o_Busy, 1);
                arb_if.i_Acknowlege = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 1) == 1) scramble(w);
                if ($urandom_range(0, 3) == 0) arb_if.i_Req[w] = 1'b0;
                @(negedge i_Clock);
                arb_if.i_Acknowlege = 1'b0;
                check("grant_pulse", arb_if.o_Bus_Grant, 0);
                check("early_ack", arb_if.o_Done, 0);
                d = $urandom_range(dmin, dmax);
                repeat (d) @(negedge i_Clock);
                check("hold_ctl", arb_if.o_Control, e_ctl);
                check("hold_ptr", arb_if.o_bram_pointer, e_ptr);
                check("hold_cnt", arb_if.o_Data_Counter, e_cnt);
                check("hold_owner", arb_if.o_Owner, oh);
                check("hold_busy", arb_if.o_Busy, 1);
                check("hold_err", arb_if.o_Error, 0);
                arb_if.i_Acknowlege = 1'b1;
                @(negedge i_Clock);
                arb_if.i_Acknowlege = 1'b0;
                check("done", arb_if.o_Done, oh);
                check("done_noerr", arb_if.o_Error, 0);
                check("busy_release", arb_if.o_Busy, 1);
                check("owner_release", arb_if.o_Owner, oh);
                pend[w]     = 1'b0;
                last_served = w;
                drive_req();
                @(negedge i_Clock);
                check("owner_clear", arb_if.o_Owner, 0);
                check("busy_clear", arb_if.o_Busy, 0);
                check("done_pulse", arb_if.o_Done, 0);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, arb_if.o_Bus_Grant, 0);
        check({tag, "_owner"}, arb_if.o_Owner, 0);
        check({tag, "_done"}, arb_if.o_Done, 0);
        check({tag, "_error"}, arb_if.o_Error, 0);
        check({tag, "_busy"}, arb_if.o_Busy, 0);
        check({tag, "_ctl"}, arb_if.o_Control, 0);
        check({tag, "_ptr"}, arb_if.o_bram_pointer, 0);
        check({tag, "_cnt"}, arb_if.o_Data_Counter, 0);
    endtask

    initial begin
        bit ok;
        int lat;
        int n;
        pend                = 2'b00;
        last_served         = 1'b1;
        first_lat           = 0;
        ctl[0] = '0; ctl[1] = '0;
        ptr[0] = '0; ptr[1] = '0;
        cnt[0] = '0; cnt[1] = '0;
        arb_if.i_Acknowlege = 1'b0;
        arb_if.i_SM_Main    = 3'd0;
        drive_req();

        repeat (3) @(negedge i_Clock);
        check_reset_outputs("rst");
        i_Reset_n = 1'b1;
        @(negedge i_Clock);

        // single TX request: one-clock grant latency, then done after ack
        set_req(0, 2'b11, 32'h100, 1);
        drive_req();
        serve_all(8, 8);
        check("lat_single", first_lat, 1);

        // both requesting, repeatedly: alternating owners
        set_req(0, 2'b10, 32'h40, 3);
        set_req(1, 2'b11, 32'h80, 7);
        drive_req();
        serve_all(0, 4);
        set_req(0, 2'b01, 32'h44, 2);
        set_req(1, 2'b00, 32'h88, 9);
        drive_req();
        serve_all(0, 4);

        // empty burst is rejected without a grant
        set_req(1, 2'b00, 32'h500, 0);
        drive_req();
        serve_all(0, 0);
        check("lat_zero_burst", first_lat, 1);

        // controller busy: hold off arbitration
        arb_if.i_SM_Main = 3'd3;
        set_req(0, 2'b10, 32'h600, 5);
        drive_req();
        for (int i = 0; i < 5; i++) begin
            @(negedge i_Clock);
            check("sm_busy_nogrant", {arb_if.o_Bus_Grant, arb_if.o_Busy}, 0);
        end
        arb_if.i_SM_Main = 3'd0;
        serve_all(0, 4);
        check("lat_after_sm", first_lat, 1);

        // stray acknowledge while idle
        arb_if.i_Acknowlege = 1'b1;
        @(negedge i_Clock);
        arb_if.i_Acknowlege = 1'b0;
        check("stray_ack_busy", arb_if.o_Busy, 0);
        check("stray_ack_done", arb_if.o_Done, 0);

`ifndef DMA_ARB_TIMEOUT_EN
        // no watchdog: a long wait for ack still completes normally
        set_req(1, 2'b01, 32'h700, 4);
        drive_req();
        serve_all(40, 40);
`else
        // watchdog: error after TMO cycles in WAIT_ACK, no done
        set_req(0, 2'b11, 32'h200, 1);
        drive_req();
        wait_event(ok, lat);
        check("tmo_grant", arb_if.o_Bus_Grant, 1);
        n = 1;
        @(negedge i_Clock);
        while ((arb_if.o_Error == 2'b00) && (n < 40)) begin
            @(negedge i_Clock);
            n++;
        end
        check("tmo_cycles", n, TMO + 1);
        check("tmo_error", arb_if.o_Error, 2'b01);
        check("tmo_nodone", arb_if.o_Done, 0);
        pend        = 2'b00;
        last_served = 1'b0;
        drive_req();
        @(negedge i_Clock);
        check("tmo_idle", arb_if.o_Busy, 0);
        check("tmo_err_pulse", arb_if.o_Error, 0);
`endif

        // randomized rounds
        for (int r = 0; r < 30; r++) begin
            pend = 2'b00;
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 2) != 0) rand_req(k);
            end
            if (pend == 2'b00) rand_req($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                arb_if.i_SM_Main = 3'($urandom_range(1, 7));
                drive_req();
                for (int i = 0; i < 3; i++) begin
                    @(negedge i_Clock);
                    check("rnd_sm_hold", {arb_if.o_Bus_Grant, arb_if.o_Busy}, 0);
                end
                arb_if.i_SM_Main = 3'd0;
            end
            drive_req();
            serve_all(0, 12);
            @(negedge i_Clock);
        end

        // reset in the middle of a transfer abandons it
        set_req(1, 2'b01, 32'h300, 4);
        drive_req();
        wait_event(ok, lat);
        check("rst_pre_grant", arb_if.o_Owner, 2'b10);
        @(negedge i_Clock);
        #2 i_Reset_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        pend        = 2'b00;
        last_served = 1'b1;
        drive_req();
        arb_if.i_Acknowlege = 1'b1;
        @(negedge i_Clock);
        arb_if.i_Acknowlege = 1'b0;
        check("rst_no_done", arb_if.o_Done, 0);
        i_Reset_n = 1'b1;
        @(negedge i_Clock);
        set_req(0, 2'b11, 32'h10, 2);
        set_req(1, 2'b11, 32'h20, 3);
        drive_req();
        wait_event(ok, lat);
        check("rst_first_owner", arb_if.o_Owner, 2'b01);
        serve_all(0, 4);

        repeat (2) @(negedge i_Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
